uart_transceiver: RTL and testbench
===================================

Name: uart_transceiver

Overview:
Full-duplex 8N1 UART between the host serial pins and the logic-analyser core. The TX side accepts bytes through the send_data/send_req/send_ready handshake and serialises them on tx. The RX side deserialises rx and presents each received byte as a one-cycle recv_data/recv_valid pulse. Both directions run from the single system clock using integer bit-period counters.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s; bit period CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (floor), must be >= 4

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
rx  input  1  serial line from host, asynchronous, idle high
tx  output  1  serial line to host, idle high
send_data  input  8  byte to transmit, sampled when send_req && send_ready
send_req  input  1  one-cycle transmit request
send_ready  output  1  high when TX is idle and can accept a byte
recv_data  output  8  last correctly received byte
recv_valid  output  1  one-cycle pulse: recv_data holds a new byte

Behaviour:
- Reset (synchronous, rst high at a clk edge): tx=1, send_ready=1, recv_data=0, recv_valid=0, both FSMs idle, all counters 0, rx synchroniser flops = 1. Reset mid-frame abandons the frame immediately; no partial byte is reported.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Every bit lasts exactly CLKS_PER_BIT clocks.
- TX FSM, states TX_IDLE, TX_START, TX_DATA, TX_STOP:
  - TX_IDLE: send_ready=1, tx=1. On send_req=1, latch send_data into the shift register and go to TX_START. On the next edge tx=0 and send_ready=0.
  - send_req while send_ready=0 is ignored; no queueing.
  - TX_START and TX_DATA each hold a bit for CLKS_PER_BIT cycles. TX_DATA uses a 3-bit index 0..7.
  - TX_STOP drives tx=1 for CLKS_PER_BIT cycles, then returns to TX_IDLE, and send_ready goes 1 on the same edge.
  - Latency: send_ready is low for exactly 10*CLKS_PER_BIT cycles per byte. A new send_req in the first ready cycle starts the next start bit with no idle gap.
  - tx and send_ready are registered outputs.
- RX path: rx passes through a 2-flop synchroniser; all decisions use the synchronised value.
- RX FSM, states RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH:
  - RX_IDLE: a low synchronised rx enters RX_START with counter cleared.
  - RX_START: at CLKS_PER_BIT/2 cycles, if rx=0 go to RX_DATA; otherwise treat it as a glitch and return to RX_IDLE.
  - RX_DATA: sample every CLKS_PER_BIT cycles (mid-bit) and shift in LSB first, 8 samples.
  - RX_STOP: sample mid stop bit.
    - If 1: recv_data <= shifted byte and recv_valid=1 for exactly one cycle, then go to RX_IDLE.
    - If 0 (framing error): no recv_valid, recv_data unchanged, go to RX_WAIT_HIGH.
  - RX_WAIT_HIGH: stay until rx=1, then go to RX_IDLE. A break condition produces no bytes.
- recv_valid never asserts twice for one frame. TX and RX are fully independent; simultaneous activity is allowed.
- Counters are wide enough for CLKS_PER_BIT-1 ($clog2). They reset to 0 on every bit boundary and never wrap mid-bit.

Optional Feature:
UART_PARITY_EN:
- Defined: an even parity bit is inserted between data bit 7 and the stop bit (TX state TX_PARITY, RX state RX_PARITY). The frame becomes 11 bits and send_ready is low for 11*CLKS_PER_BIT cycles.
- Defined, RX parity mismatch: the byte is discarded (no recv_valid); the stop bit is still checked before going to RX_IDLE or RX_WAIT_HIGH.
- Undefined: 8N1 exactly as above, and no parity logic is present.

Test Plan:
All scenarios use CLK_FREQ=1000000, BAUD_RATE=62500 (CLKS_PER_BIT=16).
1. TX byte: send_req pulse with send_data=0xA5 -> send_ready 0 next cycle; tx = 0 x16, then 1,0,1,0,0,1,0,1 (16 cycles each), then 1 x16; send_ready returns 1 exactly 160 cycles after the request; a second send_req during busy is ignored.
2. RX byte: drive an ideal 8N1 frame of 0x3C on rx -> exactly one recv_valid pulse about 152 cycles after the start edge (+2 sync), with recv_data=0x3C held afterwards.
3. Glitch: rx low for 4 cycles, then high -> no recv_valid, FSM back in RX_IDLE; a following 0x81 frame is received correctly.
4. Framing error: 0x55 frame with stop bit 0, line held low 40 cycles, then high -> no recv_valid, recv_data unchanged; the next 0xF0 frame gives recv_valid with 0xF0.
5. Loopback tx->rx with bytes 0x00, 0xFF, 0x5A sent back-to-back -> three recv_valid pulses carrying the same bytes in order; no idle gap on tx.
6. Reset mid-operation: assert rst during TX data bit 3 and RX data bit 5 -> next edge tx=1, send_ready=1, recv_valid=0; no byte reported.

Source files
------------

// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex UART between the host serial pins and the
// logic-analyser core. Both directions run from clk with integer bit-period
// counters (CLKS_PER_BIT = CLK_FREQ / BAUD_RATE, must be >= 4).
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   rx          serial line from host (asynchronous, idle high)
//   tx          serial line to host (registered, idle high)
//   send_data   byte to transmit, taken when send_req && send_ready
//   send_req    one-cycle transmit request
//   send_ready  TX idle and able to accept a byte (registered)
//   recv_data   last correctly received byte
//   recv_valid  one-cycle pulse when recv_data is updated
//
// Build option: define UART_PARITY_EN to insert an even parity bit between
// data bit 7 and the stop bit in both directions (8E1). Undefined gives 8N1.

module uart_transceiver #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic [7:0] send_data,
    input  logic       send_req,
    output logic       send_ready,
    output logic [7:0] recv_data,
    output logic       recv_valid
);

    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;
`else
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
`endif

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t     tx_state, tx_state_nxt;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]    tx_idx, tx_idx_nxt;
    logic [7:0]    tx_shift, tx_shift_nxt;
    logic          tx_nxt, ready_nxt;
`ifdef UART_PARITY_EN
    logic          tx_par, tx_par_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            tx_idx     <= '0;
            tx_shift   <= '0;
            tx         <= 1'b1;
            send_ready <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par     <= 1'b0;
`endif
        end else begin
            tx_state   <= tx_state_nxt;
            tx_cnt     <= tx_cnt_nxt;
            tx_idx     <= tx_idx_nxt;
            tx_shift   <= tx_shift_nxt;
            tx         <= tx_nxt;
            send_ready <= ready_nxt;
`ifdef UART_PARITY_EN
            tx_par     <= tx_par_nxt;
`endif
        end
    end

    // tx is registered, so each branch sets the line value for the bit that
    // starts on the coming edge.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_idx_nxt   = tx_idx;
        tx_shift_nxt = tx_shift;
        tx_nxt       = tx;
        ready_nxt    = send_ready;
`ifdef UART_PARITY_EN
        tx_par_nxt   = tx_par;
`endif
        case (tx_state)
            TX_IDLE: begin
                tx_nxt     = 1'b1;
                ready_nxt  = 1'b1;
                tx_cnt_nxt = '0;
                if (send_req) begin
                    tx_shift_nxt = send_data;
`ifdef UART_PARITY_EN
                    tx_par_nxt   = ^send_data;
`endif
                    tx_state_nxt = TX_START;
                    tx_nxt       = 1'b0;
                    ready_nxt    = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_idx_nxt   = '0;
                    tx_state_nxt = TX_DATA;
                    tx_nxt       = tx_shift[0];
                end else begin
                    tx_cnt_nxt = tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt = '0;
                    if (tx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_nxt = TX_PARITY;
                        tx_nxt       = tx_par;
`else
                        tx_state_nxt = TX_STOP;
                        tx_nxt       = 1'b1;
`endif
                    end else begin
                        tx_idx_nxt   = tx_idx + 3'd1;
                        tx_shift_nxt = {1'b0, tx_shift[7:1]};
                        tx_nxt       = tx_shift[1];
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = TX_STOP;
                    tx_nxt       = 1'b1;
                end else begin
                    tx_cnt_nxt = tx_cnt + 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = TX_IDLE;
                    tx_nxt       = 1'b1;
                    ready_nxt    = 1'b1;
                end else begin
                    tx_cnt_nxt = tx_cnt + 1'b1;
                end
            end
            default: begin
                tx_state_nxt = TX_IDLE;
                tx_cnt_nxt   = '0;
                tx_nxt       = 1'b1;
                ready_nxt    = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic          rx_s1, rx_s;
    rx_state_t     rx_state, rx_state_nxt;
    logic [CW-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]    rx_idx, rx_idx_nxt;
    logic [7:0]    rx_shift, rx_shift_nxt;
    logic [7:0]    data_nxt;
    logic          valid_nxt;
`ifdef UART_PARITY_EN
    logic          rx_par_ok, rx_par_ok_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1      <= 1'b1;
            rx_s       <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            recv_data  <= '0;
            recv_valid <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_ok  <= 1'b0;
`endif
        end else begin
            rx_s1      <= rx;
            rx_s       <= rx_s1;
            rx_state   <= rx_state_nxt;
            rx_cnt     <= rx_cnt_nxt;
            rx_idx     <= rx_idx_nxt;
            rx_shift   <= rx_shift_nxt;
            recv_data  <= data_nxt;
            recv_valid <= valid_nxt;
`ifdef UART_PARITY_EN
            rx_par_ok  <= rx_par_ok_nxt;
`endif
        end
    end

    // After the half-bit start check, every later sample lands a full bit
    // period on, i.e. in the middle of each bit.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_idx_nxt   = rx_idx;
        rx_shift_nxt = rx_shift;
        data_nxt     = recv_data;
        valid_nxt    = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_ok_nxt = rx_par_ok;
`endif
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_nxt = '0;
                if (!rx_s) rx_state_nxt = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt = '0;
                    rx_idx_nxt = '0;
                    rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {rx_s, rx_shift[7:1]};
                    if (rx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_nxt = RX_PARITY;
`else
                        rx_state_nxt = RX_STOP;
`endif
                    end else begin
                        rx_idx_nxt = rx_idx + 3'd1;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt    = '0;
                    rx_par_ok_nxt = ((^rx_shift) == rx_s);
                    rx_state_nxt  = RX_STOP;
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
`endif
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt = '0;
                    if (rx_s) begin
                        rx_state_nxt = RX_IDLE;
`ifdef UART_PARITY_EN
                        if (rx_par_ok) begin
                            data_nxt  = rx_shift;
                            valid_nxt = 1'b1;
                        end
`else
                        data_nxt  = rx_shift;
                        valid_nxt = 1'b1;
`endif
                    end else begin
                        // framing error / break: wait for the line to recover
                        rx_state_nxt = RX_WAIT_HIGH;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                rx_cnt_nxt = '0;
                if (rx_s) rx_state_nxt = RX_IDLE;
            end
            default: begin
                rx_state_nxt = RX_IDLE;
                rx_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver at CLKS_PER_BIT = 16 (1 MHz / 62500).
// Clock period 10; inputs driven and outputs sampled 1 time unit after posedge.
module tb_uart_transceiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       rx_line;
    logic       tx;
    logic [7:0] send_data = 8'h00;
    logic       send_req = 1'b0;
    logic       send_ready;
    logic [7:0] recv_data;
    logic       recv_valid;

    int n_chk = 0;
    int n_fail = 0;

    assign rx_line = loop_en ? tx : rx_drv;

    uart_transceiver #(.CLK_FREQ(1000000), .BAUD_RATE(62500)) dut (
        .clk(clk), .rst(rst), .rx(rx_line), .tx(tx),
        .send_data(send_data), .send_req(send_req), .send_ready(send_ready),
        .recv_data(recv_data), .recv_valid(recv_valid)
    );

    always #5 clk = ~clk;

    // recv_valid monitor: log every pulse with its byte and time
    int         rv_cnt = 0;
    time        rv_t = 0;
    logic [7:0] rv_log [64];
    always @(negedge clk) begin
        if (recv_valid === 1'b1) begin
            if (rv_cnt < 64) rv_log[rv_cnt] = recv_data;
            rv_t = $time;
            rv_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stopb);
        logic [9:0] fr;
        fr = {stopb, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rx_drv = fr[b];
            repeat (16) tick();
        end
    endtask

    initial begin
        logic [9:0] fr;
        logic [7:0] lb [3];
        int         base;
        int         n;
        time        t_drv;

        // ---- reset state
        repeat (3) tick();
        chk("rst_tx", tx, 1);
        chk("rst_ready", send_ready, 1);
        chk("rst_valid", recv_valid, 0);
        chk("rst_data", recv_data, 8'h00);
        rst = 1'b0;
        repeat (5) tick();

        // ---- 1: TX 0xA5, one ignored request while busy
        fr = {1'b1, 8'hA5, 1'b0};
        send_data = 8'hA5;
        send_req  = 1'b1;
        tick();
        send_req  = 1'b0;
        for (int i = 0; i < 160; i++) begin
            chk($sformatf("tx_a5_bit%0d_cyc%0d", i / 16, i % 16), tx, fr[i / 16]);
            chk("tx_busy_ready", send_ready, 0);
            send_req  = (i == 40);
            send_data = 8'h00;
            tick();
        end
        send_req = 1'b0;
        chk("tx_ready_back", send_ready, 1);
        for (int i = 0; i < 20; i++) begin
            chk("tx_idle_after", tx, 1);
            tick();
        end

        // ---- 2: RX 0x3C, valid 152 + 2 sync cycles after the start edge
        base  = rv_cnt;
        t_drv = $time;
        rx_frame(8'h3C, 1'b1);
        // first sampling edge at +9, valid after edge 154, seen at negedge +5
        chk("rx_3c_time", 32'(rv_t - t_drv), 32'd1554);
        chk("rx_3c_count", rv_cnt - base, 1);
        chk("rx_3c_byte", rv_log[base], 8'h3C);
        repeat (20) tick();
        chk("rx_3c_held", recv_data, 8'h3C);
        chk("rx_3c_once", rv_cnt - base, 1);

        // ---- 3: glitch then 0x81
        base   = rv_cnt;
        rx_drv = 1'b0;
        repeat (4) tick();
        rx_drv = 1'b1;
        repeat (30) tick();
        chk("glitch_no_valid", rv_cnt - base, 0);
        rx_frame(8'h81, 1'b1);
        repeat (5) tick();
        chk("rx_81_count", rv_cnt - base, 1);
        chk("rx_81_byte", recv_data, 8'h81);

        // ---- 4: framing error on 0x55, then 0xF0
        base = rv_cnt;
        rx_frame(8'h55, 1'b0);
        repeat (40) tick();
        rx_drv = 1'b1;
        repeat (20) tick();
        chk("frm_no_valid", rv_cnt - base, 0);
        chk("frm_data_kept", recv_data, 8'h81);
        rx_frame(8'hF0, 1'b1);
        repeat (5) tick();
        chk("rx_f0_count", rv_cnt - base, 1);
        chk("rx_f0_byte", recv_data, 8'hF0);

        // ---- 5: loopback, back-to-back 0x00 0xFF 0x5A
        loop_en = 1'b1;
        repeat (5) tick();
        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A;
        base = rv_cnt;
        send_data = lb[0];
        send_req  = 1'b1;
        tick();
        send_req  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("lb_start_%0d", k), tx, 0);
            n = 0;
            while (!send_ready && n < 200) begin
                tick();
                n++;
            end
            chk($sformatf("lb_busy_len_%0d", k), n, 160);
            if (k < 2) begin
                send_data = lb[k + 1];
                send_req  = 1'b1;
                tick();
                send_req  = 1'b0;
            end
        end
        repeat (10) tick();
        chk("lb_count", rv_cnt - base, 3);
        for (int j = 0; j < 3; j++)
            chk($sformatf("lb_byte_%0d", j), rv_log[base + j], lb[j]);
        loop_en = 1'b0;
        repeat (5) tick();

        // ---- 6: reset during TX bit 3 and RX bit 5
        base = rv_cnt;
        fr   = {1'b1, 8'hC3, 1'b0};
        for (int i = 0; i < 95; i++) begin
            rx_drv    = fr[i / 16];
            send_data = 8'h5A;
            send_req  = (i == 20);
            tick();
        end
        send_req = 1'b0;
        chk("pre_rst_busy", send_ready, 0);
        rst = 1'b1;
        tick();
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_ready", send_ready, 1);
        chk("mid_rst_valid", recv_valid, 0);
        chk("mid_rst_data", recv_data, 8'h00);
        rst    = 1'b0;
        rx_drv = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (tx !== 1'b1) n++;
            tick();
        end
        chk("post_rst_tx_idle", n, 0);
        chk("post_rst_no_byte", rv_cnt - base, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
